instr_fetch: RTL

Instruction fetch unit on the producer side of the opcode interface. It holds the PC and issues word requests to instruction memory with one request outstanding at a time. Returned words are buffered in a small FIFO and handed to decode with a valid/ready handshake; `opcode` feeds the main control decoder. Branch/jump resolution drives the redirect input, which flushes the unit and restarts fetch at the target.

---
 rtl/instr_fetch.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding word fetch into a small FIFO with a valid/ready decode port.
// Define IFETCH_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
module instr_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   req_pc_reg, req_pc_next;
    logic          imem_req_reg;

    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;

    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          bypass;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign fifo_empty = (count_reg == '0);

`ifdef IFETCH_BYPASS_EN
    assign bypass = fifo_empty && (state_reg == WAIT) && imem_rvalid && !redirect;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word taken by decode this cycle never occupies a slot.
    assign pop  = !fifo_empty && instr_ready;
    assign push = (state_reg == WAIT) && imem_rvalid && !redirect && !(bypass && instr_ready);

    always_comb begin
        count_next = count_reg;
        if (redirect) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_pc_next   = req_pc_reg;
        case (state_reg)
            IDLE: state_next = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_next    = WAIT;
                    req_pc_next   = fetch_pc_reg;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_next = (count_next < DEPTH_C) ? REQ : HOLD;
                end
            end
            HOLD: begin
                if (count_next < DEPTH_C) begin
                    state_next = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        // Redirect wins; an already-granted request still owes a response that must be dropped.
        if (redirect) begin
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
            case (state_reg)
                REQ:        state_next = imem_gnt ? DROP : REQ;
                WAIT, DROP: state_next = imem_rvalid ? REQ : DROP;
                default:    state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= PC_RESET;
            req_pc_reg   <= '0;
            imem_req_reg <= 1'b0;
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            req_pc_reg   <= req_pc_next;
            imem_req_reg <= (state_next == REQ);
            count_reg    <= count_next;
            if (redirect) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                end
                if (pop) begin
                    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr[wr_ptr_reg] <= imem_rdata;
            fifo_pc[wr_ptr_reg]    <= req_pc_reg;
        end
    end

    always_comb begin
        instr_valid = !fifo_empty;
        instr       = fifo_instr[rd_ptr_reg];
        instr_pc    = fifo_pc[rd_ptr_reg];
        if (bypass) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = req_pc_reg;
        end
    end

    assign opcode    = instr[31:26];
    assign imem_req  = imem_req_reg;
    assign imem_addr = fetch_pc_reg;

endmodule
